// File: rtl/bubble_host_sequencer.sv
// bubble_host_sequencer
// Host-side waveform generator for bubble memory access. Drives the
// shift enable (nBSEN), replicator enable (nREPEN) and bootloop enable
// (nBOOTEN) strobes through an optional bootloader loop followed by a
// programmable number of page reads. Every phase length is a parameter
// expressed in MCLK cycles.
//
// Ports:
//   i_mclk        system clock
//   i_mrst_n      synchronous active-low reset
//   i_start       begin a sequence (only honoured while idle)
//   i_skip_boot   sampled with i_start; 1 = go straight to the page reads
//   i_abort       return to idle on the next cycle, no DONE pulse
//   i_page_count  number of pages to read, sampled with i_start
//   o_nbsen       bubble shift enable, active-low
//   o_nrepen      replicator enable, active-low
//   o_nbooten     bootloop enable, active-low
//   o_busy        high whenever the sequencer is not idle
//   o_done        one-cycle pulse on normal completion
//   o_page_num    pages completed in the current sequence (saturating)

module bubble_host_sequencer #(
    parameter int CNT_W          = 24,
    parameter int PAGE_W         = 11,
    parameter int BOOT_SETUP     = 38,
    parameter int BOOT_REP_LOW   = 687,
    parameter int BOOT_REP_HIGH  = 1233,
    parameter int BOOT_LOOPS     = 2276,
    parameter int BOOT_TAIL      = 1000,
    parameter int BOOTEN_DELAY   = 423,
    parameter int PAGE_GAP       = 75000,
    parameter int PAGE_REP_DELAY = 25000,
    parameter int PAGE_REP_LOW   = 683,
    parameter int PAGE_SHIFT     = 675660,
    parameter int DONE_TAIL      = 1000
) (
    input  logic              i_mclk,
    input  logic              i_mrst_n,
    input  logic              i_start,
    input  logic              i_skip_boot,
    input  logic              i_abort,
    input  logic [PAGE_W-1:0] i_page_count,
    output logic              o_nbsen,
    output logic              o_nrepen,
    output logic              o_nbooten,
    output logic              o_busy,
    output logic              o_done,
    output logic [PAGE_W-1:0] o_page_num
);

    typedef enum logic [3:0] {
        IDLE, B_SETUP, B_REPLO, B_REPHI, B_TAIL, B_DELAY,
        P_GAP, P_PRE, P_REPLO, P_POST, FIN
    } state_t;

    // Counter reload values: a phase of N cycles loads N-1 and ends at 0.
    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(BOOT_SETUP - 1);
    localparam logic [CNT_W-1:0] L_BREPLO = CNT_W'(BOOT_REP_LOW - 1);
    localparam logic [CNT_W-1:0] L_BREPHI = CNT_W'(BOOT_REP_HIGH - 1);
    localparam logic [CNT_W-1:0] L_LOOPS  = CNT_W'(BOOT_LOOPS);
    localparam logic [CNT_W-1:0] L_BTAIL  = CNT_W'(BOOT_TAIL - 1);
    localparam logic [CNT_W-1:0] L_BDELAY = CNT_W'(BOOTEN_DELAY - 1);
    localparam logic [CNT_W-1:0] L_GAP    = CNT_W'(PAGE_GAP - 1);
    localparam logic [CNT_W-1:0] L_PRE    = CNT_W'(PAGE_REP_DELAY - 1);
    localparam logic [CNT_W-1:0] L_PREPLO = CNT_W'(PAGE_REP_LOW - 1);
    localparam logic [CNT_W-1:0] L_POST   = CNT_W'(PAGE_SHIFT - PAGE_REP_DELAY - PAGE_REP_LOW - 1);
    localparam logic [CNT_W-1:0] L_FIN    = CNT_W'(DONE_TAIL - 1);

    localparam bit L_PARAMS_OK =
        (BOOT_SETUP >= 1) && (BOOT_REP_LOW >= 1) && (BOOT_REP_HIGH >= 1) &&
        (BOOT_LOOPS >= 1) && (BOOT_TAIL >= 1) && (BOOTEN_DELAY >= 1) &&
        (PAGE_GAP >= 1) && (PAGE_REP_DELAY >= 1) && (PAGE_REP_LOW >= 1) &&
        (PAGE_SHIFT >= 1) && (DONE_TAIL >= 1) &&
        (PAGE_REP_DELAY + PAGE_REP_LOW < PAGE_SHIFT);

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [CNT_W-1:0]  r_loops, w_loops;
    logic [PAGE_W-1:0] r_pageTotal, w_pageTotal;
    logic [PAGE_W-1:0] r_pageNum, w_pageNum;
    logic              r_nbsen, w_nbsen;
    logic              r_nrepen, w_nrepen;
    logic              r_nbooten, w_nbooten;
    logic              r_busy, w_busy;
    logic              r_done, w_done;
    logic              w_phaseEnd;
    logic [PAGE_W-1:0] w_pageInc;

    assign w_phaseEnd = (r_cnt == '0);
    // Completed-page count stops at all-ones instead of wrapping.
    assign w_pageInc  = (r_pageNum == '1) ? r_pageNum : r_pageNum + PAGE_W'(1);

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so the pins change exactly on phase boundaries.
    // ABORT is checked first so it overrides START and any phase in flight.
    always_comb begin
        w_state     = r_state;
        w_cnt       = w_phaseEnd ? r_cnt : r_cnt - CNT_W'(1);
        w_loops     = r_loops;
        w_pageTotal = r_pageTotal;
        w_pageNum   = r_pageNum;
        w_nbsen     = r_nbsen;
        w_nrepen    = r_nrepen;
        w_nbooten   = r_nbooten;
        w_done      = 1'b0;

        if (i_abort) begin
            w_state   = IDLE;
            w_nbsen   = 1'b1;
            w_nrepen  = 1'b1;
            w_nbooten = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        w_pageTotal = i_page_count;
                        w_pageNum   = '0;
                        if (!i_skip_boot) begin
                            w_state = B_SETUP;
                            w_cnt   = L_SETUP;
                            w_nbsen = 1'b0;
                        end else begin
                            w_nbooten = 1'b1;
                            // A zero page count skips straight to the finish tail.
                            if (i_page_count == '0) begin
                                w_state = FIN;
                                w_cnt   = L_FIN;
                            end else begin
                                w_state = P_GAP;
                                w_cnt   = L_GAP;
                            end
                        end
                    end
                end
                B_SETUP: if (w_phaseEnd) begin
                    w_state  = B_REPLO;
                    w_cnt    = L_BREPLO;
                    w_nrepen = 1'b0;
                    w_loops  = CNT_W'(1);
                end
                B_REPLO: if (w_phaseEnd) begin
                    w_state  = B_REPHI;
                    w_cnt    = L_BREPHI;
                    w_nrepen = 1'b1;
                end
                B_REPHI: if (w_phaseEnd) begin
                    // r_loops counts pulses already issued, including the one just ended.
                    if (r_loops < L_LOOPS) begin
                        w_state  = B_REPLO;
                        w_cnt    = L_BREPLO;
                        w_nrepen = 1'b0;
                        w_loops  = r_loops + CNT_W'(1);
                    end else begin
                        w_state = B_TAIL;
                        w_cnt   = L_BTAIL;
                    end
                end
                B_TAIL: if (w_phaseEnd) begin
                    w_state = B_DELAY;
                    w_cnt   = L_BDELAY;
                    w_nbsen = 1'b1;
                end
                B_DELAY: if (w_phaseEnd) begin
                    w_nbooten = 1'b1;
                    if (r_pageTotal == '0) begin
                        w_state = FIN;
                        w_cnt   = L_FIN;
                    end else begin
                        w_state = P_GAP;
                        w_cnt   = L_GAP;
                    end
                end
                P_GAP: if (w_phaseEnd) begin
                    w_state = P_PRE;
                    w_cnt   = L_PRE;
                    w_nbsen = 1'b0;
                end
                P_PRE: if (w_phaseEnd) begin
                    w_state  = P_REPLO;
                    w_cnt    = L_PREPLO;
                    w_nrepen = 1'b0;
                end
                P_REPLO: if (w_phaseEnd) begin
                    w_state  = P_POST;
                    w_cnt    = L_POST;
                    w_nrepen = 1'b1;
                end
                P_POST: if (w_phaseEnd) begin
                    w_nbsen   = 1'b1;
                    w_pageNum = w_pageInc;
                    if (w_pageInc < r_pageTotal) begin
                        w_state = P_GAP;
                        w_cnt   = L_GAP;
                    end else begin
                        w_state = FIN;
                        w_cnt   = L_FIN;
                    end
                end
                FIN: if (w_phaseEnd) begin
                    w_state   = IDLE;
                    w_done    = 1'b1;
                    w_nbooten = 1'b0;
                end
                default: begin
                    w_state   = IDLE;
                    w_nbsen   = 1'b1;
                    w_nrepen  = 1'b1;
                    w_nbooten = 1'b0;
                end
            endcase
        end

        w_busy = (w_state != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_mclk) begin
        if (!i_mrst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_loops     <= '0;
            r_pageTotal <= '0;
            r_pageNum   <= '0;
            r_nbsen     <= 1'b1;
            r_nrepen    <= 1'b1;
            r_nbooten   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_loops     <= w_loops;
            r_pageTotal <= w_pageTotal;
            r_pageNum   <= w_pageNum;
            r_nbsen     <= w_nbsen;
            r_nrepen    <= w_nrepen;
            r_nbooten   <= w_nbooten;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    // Simulation-only guard against parameter sets that would produce
    // zero-length or overlapping phases.
    always @(posedge i_mclk) begin
        assert (L_PARAMS_OK)
            else $error("bubble_host_sequencer: illegal timing parameters");
    end

    assign o_nbsen    = r_nbsen;
    assign o_nrepen   = r_nrepen;
    assign o_nbooten  = r_nbooten;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_page_num = r_pageNum;

endmodule

// File: tb/tb_bubble_host_sequencer.sv
// tb_bubble_host_sequencer
// Directed bench for bubble_host_sequencer using short phase lengths.
// Cycle k is the interval following the (k-1)th rising edge after START is
// sampled (edge 0), so cycle 1 is the first cycle that shows START's effect.
// Observed vector layout: {nbsen, nrepen, nbooten, busy, done, page[10:0]}.

module tb_bubble_host_sequencer;

    logic        clk = 1'b0;
    logic        mrstN;
    logic        start;
    logic        skipBoot;
    logic        abort;
    logic [10:0] pageCount;
    logic        nbsen, nrepen, nbooten, busy, done;
    logic [10:0] pageNum;
    logic [15:0] got;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    assign got = {nbsen, nrepen, nbooten, busy, done, pageNum};

    bubble_host_sequencer #(
        .CNT_W(24), .PAGE_W(11),
        .BOOT_SETUP(4), .BOOT_REP_LOW(3), .BOOT_REP_HIGH(5), .BOOT_LOOPS(2),
        .BOOT_TAIL(6), .BOOTEN_DELAY(2), .PAGE_GAP(10), .PAGE_REP_DELAY(4),
        .PAGE_REP_LOW(3), .PAGE_SHIFT(20), .DONE_TAIL(5)
    ) dut (
        .i_mclk(clk),
        .i_mrst_n(mrstN),
        .i_start(start),
        .i_skip_boot(skipBoot),
        .i_abort(abort),
        .i_page_count(pageCount),
        .o_nbsen(nbsen),
        .o_nrepen(nrepen),
        .o_nbooten(nbooten),
        .o_busy(busy),
        .o_done(done),
        .o_page_num(pageNum)
    );

    // Reference waveform: full boot followed by two pages.
    function automatic logic [15:0] expFull(input int c);
        logic nb, nr, nbo, bz, dn;
        logic [10:0] pg;
        nb  = !((c >= 1 && c <= 26) || (c >= 39 && c <= 58) || (c >= 69 && c <= 88));
        nr  = !((c >= 5 && c <= 7) || (c >= 13 && c <= 15) ||
                (c >= 43 && c <= 45) || (c >= 73 && c <= 75));
        nbo = (c >= 29 && c <= 93);
        bz  = (c >= 1 && c <= 93);
        dn  = (c == 94);
        pg  = (c >= 89) ? 11'd2 : (c >= 59) ? 11'd1 : 11'd0;
        return {nb, nr, nbo, bz, dn, pg};
    endfunction

    // Boot skipped, one page.
    function automatic logic [15:0] expSkipOne(input int c);
        logic nb, nr, nbo, bz, dn;
        logic [10:0] pg;
        nb  = !(c >= 11 && c <= 30);
        nr  = !(c >= 15 && c <= 17);
        nbo = (c >= 1 && c <= 35);
        bz  = (c >= 1 && c <= 35);
        dn  = (c == 36);
        pg  = (c >= 31) ? 11'd1 : 11'd0;
        return {nb, nr, nbo, bz, dn, pg};
    endfunction

    // Boot skipped, zero pages: only the finish tail runs.
    function automatic logic [15:0] expZero(input int c);
        logic nbo, bz, dn;
        nbo = (c >= 1 && c <= 5);
        bz  = (c >= 1 && c <= 5);
        dn  = (c == 6);
        return {1'b1, 1'b1, nbo, bz, dn, 11'd0};
    endfunction

    // Presents START for one sampling edge and leaves time at cycle 1.
    task automatic startSeq(input logic skip, input logic [10:0] count);
        start     = 1'b1;
        skipBoot  = skip;
        pageCount = count;
        @(posedge clk); #1;
        start    = 1'b0;
        skipBoot = 1'b0;
    endtask

    // Reset held low with START asserted must keep everything idle.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            testsRun++;
            if (got !== 16'b11000_00000000000) begin
                testsFailed++;
                $display("[TB] FAIL reset edge %0d: got %b expected %b", i, got, 16'b11000_00000000000);
            end
        end
        mrstN = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        testsRun++;
        if (got !== 16'b11000_00000000000) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got %b expected %b", got, 16'b11000_00000000000);
        end
    endtask

    task automatic test_full_boot();
        logic [15:0] exp;
        startSeq(1'b0, 11'd2);
        for (int c = 1; c <= 96; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            exp = expFull(c);
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL full_boot cycle %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    task automatic test_skip_boot();
        logic [15:0] exp;
        startSeq(1'b1, 11'd1);
        for (int c = 1; c <= 38; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            exp = expSkipOne(c);
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL skip_boot cycle %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    task automatic test_zero_pages();
        logic [15:0] exp;
        startSeq(1'b1, 11'd0);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            exp = expZero(c);
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL zero_pages cycle %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    // ABORT is high during cycle abortCycle; from the next cycle the block
    // must be idle with PAGE_NUM frozen. withStart also raises START (with a
    // different setup) alongside ABORT, which must be ignored.
    task automatic test_abort(input int abortCycle, input bit withStart);
        logic [15:0] exp;
        logic [15:0] atAbort;
        atAbort = expFull(abortCycle);
        startSeq(1'b0, 11'd2);
        for (int c = 1; c <= abortCycle + 6; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            exp = (c <= abortCycle) ? expFull(c) : {5'b11000, atAbort[10:0]};
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL abort@%0d cycle %0d: got %b expected %b", abortCycle, c, got, exp);
            end
            if (c == abortCycle) begin
                abort = 1'b1;
                if (withStart) begin
                    start     = 1'b1;
                    skipBoot  = 1'b1;
                    pageCount = 11'd1;
                end
            end else if (c == abortCycle + 1) begin
                abort    = 1'b0;
                start    = 1'b0;
                skipBoot = 1'b0;
            end
        end
    endtask

    // A second START mid-run with different settings must change nothing.
    task automatic test_start_while_busy();
        logic [15:0] exp;
        startSeq(1'b0, 11'd2);
        for (int c = 1; c <= 96; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            exp = expFull(c);
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL start_while_busy cycle %0d: got %b expected %b", c, got, exp);
            end
            if (c == 30) begin
                start     = 1'b1;
                skipBoot  = 1'b1;
                pageCount = 11'd0;
            end else if (c == 31) begin
                start     = 1'b0;
                skipBoot  = 1'b0;
                pageCount = 11'd2;
            end
        end
    endtask

    // START and ABORT together while idle: stays idle, PAGE_NUM untouched.
    task automatic test_start_abort_idle(input logic [10:0] heldPage);
        logic [15:0] exp;
        exp   = {5'b11000, heldPage};
        abort = 1'b1;
        startSeq(1'b0, 11'd2);
        abort = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            testsRun++;
            if (got !== exp) begin
                testsFailed++;
                $display("[TB] FAIL start_abort_idle cycle %0d: got %b expected %b", c, got, exp);
            end
        end
    endtask

    initial begin
        mrstN     = 1'b0;
        start     = 1'b1;
        skipBoot  = 1'b0;
        abort     = 1'b0;
        pageCount = 11'd2;

        test_reset();
        test_full_boot();
        test_skip_boot();
        test_zero_pages();
        test_abort(14, 1'b0);
        test_full_boot();
        test_abort(70, 1'b1);
        test_start_while_busy();
        test_start_abort_idle(11'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
